w25q32jv_prog_seq: RTL and testbench

- Command sequencer for the W25Q32JV flash. It drives a variable-length SPI master through a full write operation: WRITE ENABLE, then PAGE PROGRAM (2 data bytes) or SECTOR ERASE (4 KB), then READ STATUS REGISTER-1 polled until BUSY clears.
- Sits between user logic and the SPI master, alongside the fast-read wrapper.
- Reports done and timeout error.

---
 rtl/w25q32jv_prog_seq.sv | 141 ++++++++++++++
 tb/tb_w25q32jv_prog_seq.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/w25q32jv_prog_seq.sv
// rtl/w25q32jv_prog_seq.sv - W25Q32JV write-enable / program-or-erase / status-poll command sequencer
module w25q32jv_prog_seq #(
    parameter int GAP_CYCLES = 3,
    parameter int POLL_MAX   = 65535
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        op_start,
    input  logic        op_sel,
    input  logic [23:0] op_addr,
    input  logic [15:0] op_wdata,
    output logic        busy,
    output logic        op_done,
    output logic        op_err,
    output logic [7:0]  status_last,
    output logic        spi_start,
    output logic [5:0]  spi_len,
    output logic [47:0] spi_data_send,
    input  logic        spi_done,
    input  logic [47:0] spi_data_recv
);

    localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GW-1:0] GAP_LAST  = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
    localparam logic [15:0]   POLL_LAST = 16'(POLL_MAX);

    typedef enum logic [3:0] {
        IDLE, WREN, WREN_WAIT, GAP1, CMD, CMD_WAIT, GAP2, POLL, POLL_WAIT, DONE, ERR
    } state_t;

    state_t        state;
    logic [GW-1:0] gap_cnt;
    logic [15:0]   poll_cnt;
    logic          sel_q;
    logic [23:0]   addr_q;
    logic [15:0]   wdata_q;

    // only the status byte of the received frame is meaningful
    logic unused_recv;
    assign unused_recv = ^spi_data_recv[47:8];

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state         <= IDLE;
            busy          <= 1'b0;
            op_done       <= 1'b0;
            op_err        <= 1'b0;
            status_last   <= 8'h00;
            spi_start     <= 1'b0;
            spi_len       <= 6'd0;
            spi_data_send <= 48'h0;
            gap_cnt       <= '0;
            poll_cnt      <= 16'd0;
            sel_q         <= 1'b0;
            addr_q        <= 24'h0;
            wdata_q       <= 16'h0;
        end else begin
            spi_start <= 1'b0;
            op_done   <= 1'b0;
            op_err    <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_start) begin
                        sel_q   <= op_sel;
                        addr_q  <= op_addr;
                        wdata_q <= op_wdata;
                        busy    <= 1'b1;
                        state   <= WREN;
                    end
                end
                WREN: begin
                    spi_start     <= 1'b1;
                    spi_len       <= 6'd8;
                    spi_data_send <= {8'h06, 40'h0};
                    state         <= WREN_WAIT;
                end
                WREN_WAIT: begin
                    if (spi_done) begin
                        gap_cnt <= '0;
                        state   <= (GAP_CYCLES == 0) ? CMD : GAP1;
                    end
                end
                GAP1: begin
                    if (gap_cnt == GAP_LAST) state <= CMD;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                CMD: begin
                    spi_start <= 1'b1;
                    if (sel_q) begin
                        spi_len       <= 6'd32;
                        spi_data_send <= {8'h20, addr_q, 16'h0};
                    end else begin
                        spi_len       <= 6'd48;
                        spi_data_send <= {8'h02, addr_q, wdata_q};
                    end
                    state <= CMD_WAIT;
                end
                CMD_WAIT: begin
                    if (spi_done) begin
                        poll_cnt <= 16'd0;
                        gap_cnt  <= '0;
                        state    <= (GAP_CYCLES == 0) ? POLL : GAP2;
                    end
                end
                GAP2: begin
                    if (gap_cnt == GAP_LAST) state <= POLL;
                    else                     gap_cnt <= gap_cnt + 1'b1;
                end
                POLL: begin
                    spi_start     <= 1'b1;
                    spi_len       <= 6'd16;
                    spi_data_send <= {8'h05, 40'h0};
                    poll_cnt      <= poll_cnt + 16'd1;
                    state         <= POLL_WAIT;
                end
                POLL_WAIT: begin
                    if (spi_done) begin
                        status_last <= spi_data_recv[7:0];
                        // pulses are raised here so they are visible while in DONE/ERR, not IDLE
                        if (!spi_data_recv[0]) begin
                            op_done <= 1'b1;
                            busy    <= 1'b0;
                            state   <= DONE;
                        end else if (poll_cnt == POLL_LAST) begin
                            op_err <= 1'b1;
                            busy   <= 1'b0;
                            state  <= ERR;
                        end else begin
                            gap_cnt <= '0;
                            state   <= (GAP_CYCLES == 0) ? POLL : GAP2;
                        end
                    end
                end
                DONE:    state <= IDLE;
                ERR:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_w25q32jv_prog_seq.sv
// tb/tb_w25q32jv_prog_seq.sv - scoreboard bench for w25q32jv_prog_seq with a stub SPI master
module tb_w25q32jv_prog_seq;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        op_start = 1'b0;
    logic        op_sel = 1'b0;
    logic [23:0] op_addr = 24'h0;
    logic [15:0] op_wdata = 16'h0;
    logic        busy, op_done, op_err, spi_start;
    logic [7:0]  status_last;
    logic [5:0]  spi_len;
    logic [47:0] spi_data_send;
    logic        spi_done = 1'b0;
    logic [47:0] spi_data_recv = 48'h0;

    w25q32jv_prog_seq #(.GAP_CYCLES(3), .POLL_MAX(4)) dut (
        .clk(clk), .arst(arst), .op_start(op_start), .op_sel(op_sel),
        .op_addr(op_addr), .op_wdata(op_wdata), .busy(busy), .op_done(op_done),
        .op_err(op_err), .status_last(status_last), .spi_start(spi_start),
        .spi_len(spi_len), .spi_data_send(spi_data_send), .spi_done(spi_done),
        .spi_data_recv(spi_data_recv)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  len;
        logic [47:0] data;
        int          cyc;
        int          gap;
    } frame_t;

    frame_t      obs_q[$];
    frame_t      exp_q[$];
    logic [7:0]  status_q[$];
    logic [7:0]  status_default = 8'h00;
    int          cyc = 0;
    int          last_done_cyc = 0;
    int          stub_cnt = 0;
    logic [7:0]  stub_rsp = 8'h00;
    int          n_cmp = 0;
    int          n_bad = 0;

    // stub SPI master: 3-cycle transactions, status bytes from status_q then status_default
    always @(negedge clk) begin
        frame_t f;
        cyc++;
        spi_done = 1'b0;
        if (arst) begin
            stub_cnt = 0;
        end else begin
            if (stub_cnt > 0) begin
                stub_cnt--;
                if (stub_cnt == 0) begin
                    spi_done      = 1'b1;
                    spi_data_recv = {40'h0, stub_rsp};
                    last_done_cyc = cyc;
                end
            end
            if (spi_start) begin
                f.len  = spi_len;
                f.data = spi_data_send;
                f.cyc  = cyc;
                f.gap  = cyc - last_done_cyc;
                obs_q.push_back(f);
                stub_cnt = 3;
                if (spi_data_send[47:40] == 8'h05)
                    stub_rsp = (status_q.size() > 0) ? status_q.pop_front() : status_default;
                else
                    stub_rsp = 8'hFF;
            end
        end
    end

    task automatic push_exp(input logic [5:0] len, input logic [47:0] data);
        frame_t f;
        f.len = len; f.data = data; f.cyc = 0; f.gap = 0;
        exp_q.push_back(f);
    endtask

    task automatic start_op(input logic sel, input logic [23:0] a, input logic [15:0] d, output int c);
        @(negedge clk); #1;
        op_sel = sel; op_addr = a; op_wdata = d; op_start = 1'b1; c = cyc;
        @(negedge clk); #1;
        op_start = 1'b0;
    endtask

    task automatic wait_end(output int nd, output int ne, output bit to);
        nd = 0; ne = 0; to = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk); #1;
            if (op_done) nd++;
            if (op_err) ne++;
            if (nd + ne > 0 && !busy) begin to = 1'b0; break; end
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); #1;
            if (op_done) nd++;
            if (op_err) ne++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1 arst = 1'b0;
        @(negedge clk); #1;
        n_cmp++;
        if ({busy, op_done, op_err, spi_start} !== 4'b0 || spi_len !== 6'd0 ||
            spi_data_send !== 48'h0 || status_last !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_state: got busy/done/err/start=%b len=%0d data=%h status=%h, expected all zero",
                     {busy, op_done, op_err, spi_start}, spi_len, spi_data_send, status_last);
        end
    endtask

    task automatic test_program;
        int c, nd, ne, k;
        bit to;
        frame_t e, o;
        obs_q.delete(); status_q = {8'h03, 8'h03, 8'h00}; status_default = 8'h00;
        push_exp(6'd8, {8'h06, 40'h0});
        push_exp(6'd48, 48'h02012345A55A);
        repeat (3) push_exp(6'd16, {8'h05, 40'h0});
        start_op(1'b0, 24'h012345, 16'hA55A, c);
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL prog_busy_rise: got %b, expected 1", busy); end
        wait_end(nd, ne, to);
        n_cmp++;
        if (to) begin n_bad++; $display("FAIL prog_timeout: no completion within bound, expected op_done"); end
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL prog_frame%0d: got none, expected len %0d data %h", k, e.len, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.len !== e.len || o.data !== e.data) begin
                    n_bad++; $display("FAIL prog_frame%0d: got len %0d data %h, expected len %0d data %h", k, o.len, o.data, e.len, e.data);
                end
                n_cmp++;
                if (k == 0 && o.cyc - c !== 2) begin
                    n_bad++; $display("FAIL prog_latency: got %0d cycles, expected 2", o.cyc - c);
                end else if (k > 0 && o.gap !== 5) begin
                    n_bad++; $display("FAIL prog_gap%0d: got %0d cycles done-to-start, expected 5 (4 between)", k, o.gap);
                end
            end
            k++;
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL prog_extra_frames: got %0d extra, expected 0", obs_q.size()); end
        n_cmp++;
        if (nd !== 1 || ne !== 0 || status_last !== 8'h00 || busy !== 1'b0) begin
            n_bad++; $display("FAIL prog_result: got done=%0d err=%0d status=%h busy=%b, expected 1 0 00 0", nd, ne, status_last, busy);
        end
    endtask

    task automatic test_erase;
        int c, nd, ne;
        bit to;
        frame_t e, o;
        obs_q.delete(); status_q = {8'h00}; status_default = 8'h00;
        push_exp(6'd8, {8'h06, 40'h0});
        push_exp(6'd32, {32'h2000F000, 16'h0});
        push_exp(6'd16, {8'h05, 40'h0});
        start_op(1'b1, 24'h00F000, 16'hFFFF, c);
        wait_end(nd, ne, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL erase_frame: got none, expected len %0d data %h", e.len, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.len !== e.len || o.data !== e.data) begin
                    n_bad++; $display("FAIL erase_frame: got len %0d data %h, expected len %0d data %h", o.len, o.data, e.len, e.data);
                end
            end
        end
        n_cmp++;
        if (to || nd !== 1 || ne !== 0 || obs_q.size() != 0) begin
            n_bad++; $display("FAIL erase_result: got done=%0d err=%0d extra=%0d timeout=%b, expected 1 0 0 0", nd, ne, obs_q.size(), to);
        end
    endtask

    task automatic test_timeout;
        int c, nd, ne;
        bit to;
        frame_t e, o;
        obs_q.delete(); status_q.delete(); status_default = 8'h01;
        push_exp(6'd8, {8'h06, 40'h0});
        push_exp(6'd48, 48'h02000100BEEF);
        repeat (4) push_exp(6'd16, {8'h05, 40'h0});
        start_op(1'b0, 24'h000100, 16'hBEEF, c);
        wait_end(nd, ne, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL tmo_frame: got none, expected len %0d data %h", e.len, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.len !== e.len || o.data !== e.data) begin
                    n_bad++; $display("FAIL tmo_frame: got len %0d data %h, expected len %0d data %h", o.len, o.data, e.len, e.data);
                end
            end
        end
        n_cmp++;
        if (obs_q.size() != 0) begin n_bad++; $display("FAIL tmo_poll_count: got %0d extra polls, expected 0", obs_q.size()); end
        n_cmp++;
        if (to || ne !== 1 || nd !== 0 || status_last !== 8'h01) begin
            n_bad++; $display("FAIL tmo_result: got err=%0d done=%0d status=%h timeout=%b, expected 1 0 01 0", ne, nd, status_last, to);
        end
        status_default = 8'h00;
    endtask

    task automatic test_back_to_back;
        int c, nd, ne, d, k;
        bit to, seen;
        frame_t e, o;
        obs_q.delete(); status_q.delete(); status_default = 8'h00;
        push_exp(6'd8, {8'h06, 40'h0});
        push_exp(6'd48, 48'h021111111234);
        push_exp(6'd16, {8'h05, 40'h0});
        push_exp(6'd8, {8'h06, 40'h0});
        push_exp(6'd32, {32'h20222000, 16'h0});
        push_exp(6'd16, {8'h05, 40'h0});
        start_op(1'b0, 24'h111111, 16'h1234, c);
        for (int i = 0; i < 200 && obs_q.size() < 2; i++) begin @(negedge clk); #1; end
        op_sel = 1'b1; op_addr = 24'hABCDEF; op_start = 1'b1;
        @(negedge clk); #1;
        op_start = 1'b0;
        seen = 1'b0; d = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk); #1;
            if (op_done) begin seen = 1'b1; d = cyc; break; end
        end
        n_cmp++;
        if (!seen) begin n_bad++; $display("FAIL b2b_first_done: got none within bound, expected op_done"); end
        op_sel = 1'b1; op_addr = 24'h222000; op_wdata = 16'h0; op_start = 1'b1;
        @(negedge clk); #1;
        @(negedge clk); #1;
        op_start = 1'b0;
        wait_end(nd, ne, to);
        n_cmp++;
        if (obs_q.size() < 4) begin
            n_bad++; $display("FAIL b2b_restart: got %0d frames, expected at least 4", obs_q.size());
        end else if (obs_q[3].cyc - d !== 3) begin
            n_bad++; $display("FAIL b2b_restart_latency: got %0d cycles after op_done, expected 3", obs_q[3].cyc - d);
        end
        k = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL b2b_frame%0d: got none, expected len %0d data %h", k, e.len, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.len !== e.len || o.data !== e.data) begin
                    n_bad++; $display("FAIL b2b_frame%0d: got len %0d data %h, expected len %0d data %h", k, o.len, o.data, e.len, e.data);
                end
            end
            k++;
        end
        n_cmp++;
        if (to || nd !== 1 || ne !== 0 || obs_q.size() != 0) begin
            n_bad++; $display("FAIL b2b_result: got done=%0d err=%0d extra=%0d timeout=%b, expected 1 0 0 0", nd, ne, obs_q.size(), to);
        end
    endtask

    task automatic test_reset_mid;
        int c, nd, ne;
        bit to;
        frame_t e, o;
        obs_q.delete(); status_q.delete(); status_default = 8'h01;
        start_op(1'b0, 24'h000200, 16'h5555, c);
        for (int i = 0; i < 200 && obs_q.size() < 3; i++) begin @(negedge clk); #1; end
        @(negedge clk); #1;
        n_cmp++;
        if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %b, expected 1", busy); end
        arst = 1'b1;
        #1;
        n_cmp++;
        if ({busy, spi_start, op_done, op_err} !== 4'b0) begin
            n_bad++; $display("FAIL rst_async: got busy/start/done/err=%b, expected 0000", {busy, spi_start, op_done, op_err});
        end
        @(negedge clk); #1;
        arst = 1'b0;
        status_default = 8'h00;
        @(negedge clk); #1;
        n_cmp++;
        if (status_last !== 8'h00 || busy !== 1'b0) begin
            n_bad++; $display("FAIL rst_idle: got status=%h busy=%b, expected 00 0", status_last, busy);
        end
        obs_q.delete();
        push_exp(6'd8, {8'h06, 40'h0});
        push_exp(6'd32, {32'h20003000, 16'h0});
        push_exp(6'd16, {8'h05, 40'h0});
        start_op(1'b1, 24'h003000, 16'h0, c);
        wait_end(nd, ne, to);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if (obs_q.size() == 0) begin
                n_bad++; $display("FAIL rst_frame: got none, expected len %0d data %h", e.len, e.data);
            end else begin
                o = obs_q.pop_front();
                if (o.len !== e.len || o.data !== e.data) begin
                    n_bad++; $display("FAIL rst_frame: got len %0d data %h, expected len %0d data %h", o.len, o.data, e.len, e.data);
                end
            end
        end
        n_cmp++;
        if (to || nd !== 1 || ne !== 0) begin
            n_bad++; $display("FAIL rst_result: got done=%0d err=%0d timeout=%b, expected 1 0 0", nd, ne, to);
        end
    endtask

    initial begin
        test_reset;
        test_program;
        test_erase;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
